// File: rtl/hazard_ctrl_if.sv
// Decode-side bus between the pipeline and hazard_ctrl: the instruction in ID,
// the EX/MEM status flags, and the stall/bubble/flush strobes returned to the pipeline.
interface hazard_ctrl_if #(
  parameter int INSTR_SIZE = 32
);
  // No ready/valid pair is involved: instr_valid qualifies instr_in in the same
  // cycle, and every strobe returned is a level that applies to the next clock edge.
  logic [INSTR_SIZE-1:0] instr_in;
  logic                  instr_valid;
  logic                  branch_taken;
  logic                  mem_busy;
  logic                  stall;
  logic                  chng2nop;
  logic                  flush_if;

  modport master (
    output instr_in, instr_valid, branch_taken, mem_busy,
    input  stall, chng2nop, flush_if
  );

  modport slave (
    input  instr_in, instr_valid, branch_taken, mem_busy,
    output stall, chng2nop, flush_if
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: 3-deep destination scoreboard plus a RUN/HOLD/FLUSH FSM.
// Define HAZARD_FWD_EN when the datapath forwards from EX/MEM and MEM/WB.
module hazard_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  hazard_ctrl_if.slave           hz,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [1:0]             state_o,
  output logic [20:0]            sb_o
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  state_t    state_q, state_d;
  sb_entry_t idex_q, exmem_q, memwb_q;
  sb_entry_t idex_d, exmem_d, memwb_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       use_rs1, use_rs2, wr_rd, dec_load, dec_jal;
  logic       hit1, hit2, hazard;
  logic       stall_raw, nop_raw, flush_raw;
  logic       unused_bits;

  assign opcode      = hz.instr_in[6:0];
  assign rd          = hz.instr_in[11:7];
  assign rs1         = hz.instr_in[19:15];
  assign rs2         = hz.instr_in[24:20];
  assign unused_bits = ^{hz.instr_in[31:25], hz.instr_in[14:12]};

  always_comb begin
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    wr_rd    = 1'b0;
    dec_load = 1'b0;
    dec_jal  = 1'b0;
    if (hz.instr_valid) begin
      case (opcode)
        OP_R:          begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
        OP_S, OP_B:    begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
        OP_I, OP_JALR: begin use_rs1 = 1'b1; wr_rd = 1'b1; end
        OP_LOAD:       begin use_rs1 = 1'b1; wr_rd = 1'b1; dec_load = 1'b1; end
        OP_LUI, OP_AUIPC: wr_rd = 1'b1;
        OP_JAL:        begin wr_rd = 1'b1; dec_jal = 1'b1; end
        default: ;
      endcase
    end
  end

  // Entries never hold rd=x0, but the source check keeps x0 reads hazard-free regardless.
  always_comb begin
`ifdef HAZARD_FWD_EN
    hit1 = use_rs1 && (rs1 != 5'd0) && idex_q.valid && idex_q.is_load && (idex_q.rd == rs1);
    hit2 = use_rs2 && (rs2 != 5'd0) && idex_q.valid && idex_q.is_load && (idex_q.rd == rs2);
`else
    hit1 = use_rs1 && (rs1 != 5'd0) &&
           ((idex_q.valid && (idex_q.rd == rs1)) || (exmem_q.valid && (exmem_q.rd == rs1)));
    hit2 = use_rs2 && (rs2 != 5'd0) &&
           ((idex_q.valid && (idex_q.rd == rs2)) || (exmem_q.valid && (exmem_q.rd == rs2)));
`endif
    hazard = hit1 || hit2;
  end

  always_comb begin
    stall_raw = 1'b0;
    nop_raw   = 1'b0;
    flush_raw = 1'b0;
    state_d   = state_q;
    if (hz.mem_busy) begin
      stall_raw = 1'b1;
    end else if (hz.branch_taken) begin
      nop_raw   = 1'b1;
      flush_raw = 1'b1;
    end else if (hazard) begin
      stall_raw = 1'b1;
      nop_raw   = 1'b1;
    end else if (dec_jal) begin
      flush_raw = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (hz.mem_busy)          state_d = HOLD;
        else if (hz.branch_taken) state_d = FLUSH;
      end
      HOLD:    if (!hz.mem_busy) state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Strobes are forced low while reset is asserted, even with mem_busy high.
  assign hz.stall    = nrst & stall_raw;
  assign hz.chng2nop = nrst & nop_raw;
  assign hz.flush_if = nrst & flush_raw;

  always_comb begin
    idex_d      = idex_q;
    exmem_d     = exmem_q;
    memwb_d     = memwb_q;
    stall_cnt_d = stall_cnt_q;
    if (!hz.mem_busy) begin
      memwb_d = exmem_q;
      exmem_d = idex_q;
      if (nop_raw || !wr_rd || (rd == 5'd0)) idex_d = '0;
      else idex_d = '{valid: 1'b1, rd: rd, is_load: dec_load};
    end
    if (stall_raw && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= RUN;
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign state_o   = state_q;
  assign sb_o      = {idex_q, exmem_q, memwb_q};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use/RAW stalls, x0 filter, control flow,
// memory freeze, reset mid-stall and stall counter saturation (second instance, width 4).
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam int LD_STALLS  = 1;
  localparam int ALU_STALLS = 0;
`else
  localparam int LD_STALLS  = 2;
  localparam int ALU_STALLS = 2;
`endif

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        nrst;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt2;
  logic [1:0]  state_o, state2_o;
  logic [20:0] sb_o, sb2_o;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  hazard_ctrl_if hz ();
  hazard_ctrl_if hz2 ();

  hazard_ctrl #(.STALL_CNT_W(16)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .hz        (hz),
    .stall_cnt (stall_cnt),
    .state_o   (state_o),
    .sb_o      (sb_o)
  );

  hazard_ctrl #(.STALL_CNT_W(4)) dut_sat (
    .clk       (clk),
    .nrst      (nrst),
    .hz        (hz2),
    .stall_cnt (stall_cnt2),
    .state_o   (state2_o),
    .sb_o      (sb2_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'b0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, 5'b0, 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd);
    return {20'b0, rd, 7'b1101111};
  endfunction

  // Scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver: apply one decode cycle at the falling edge, check strobes {stall,chng2nop,flush_if}.
  task automatic step(input string tag, input logic [31:0] ins, input logic v,
                      input logic bt, input logic mb, input logic [2:0] exp_o);
    @(negedge clk);
    hz.instr_in     = ins;
    hz.instr_valid  = v;
    hz.branch_taken = bt;
    hz.mem_busy     = mb;
    #1;
    check_eq(tag, {29'b0, hz.stall, hz.chng2nop, hz.flush_if}, {29'b0, exp_o});
    if (exp_o[2]) exp_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", NOP, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  initial begin
    nrst             = 1'b0;
    hz.instr_in      = enc_add(5'd4, 5'd3, 5'd2);
    hz.instr_valid   = 1'b1;
    hz.branch_taken  = 1'b0;
    hz.mem_busy      = 1'b1;
    hz2.instr_in     = NOP;
    hz2.instr_valid  = 1'b0;
    hz2.branch_taken = 1'b0;
    hz2.mem_busy     = 1'b0;

    // Reset: strobes low even with mem_busy high
    #3;
    check_eq("rst_out", {29'b0, hz.stall, hz.chng2nop, hz.flush_if}, 32'd0);
    check_eq("rst_cnt", {16'b0, stall_cnt}, 32'd0);
    check_eq("rst_state", {30'b0, state_o}, {30'b0, S_RUN});
    hz.mem_busy = 1'b0;
    #2;
    check_eq("rst_out_5", {29'b0, hz.stall, hz.chng2nop, hz.flush_if}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Load-use
    step("lu_lw", enc_lw(5'd4, 5'd3), 1'b1, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < LD_STALLS; i++)
      step("lu_stall", enc_add(5'd5, 5'd4, 5'd2), 1'b1, 1'b0, 1'b0, 3'b110);
    step("lu_go", enc_add(5'd5, 5'd4, 5'd2), 1'b1, 1'b0, 1'b0, 3'b000);
    idle(3);

    // ALU to branch
    step("alu_add", enc_add(5'd4, 5'd3, 5'd2), 1'b1, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < ALU_STALLS; i++)
      step("alu_stall", enc_beq(5'd4, 5'd2), 1'b1, 1'b0, 1'b0, 3'b110);
    step("alu_go", enc_beq(5'd4, 5'd2), 1'b1, 1'b0, 1'b0, 3'b000);
    idle(3);

    // x0 never creates a hazard
    step("x0_wr", enc_add(5'd0, 5'd3, 5'd2), 1'b1, 1'b0, 1'b0, 3'b000);
    step("x0_rd", enc_add(5'd5, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0, 3'b000);
    idle(3);

    // jal: one-cycle fetch redirect
    step("jal", enc_jal(5'd1), 1'b1, 1'b0, 1'b0, 3'b001);
    step("jal_after", NOP, 1'b0, 1'b0, 1'b0, 3'b000);
    idle(3);
    check_eq("cnt_data", {16'b0, stall_cnt}, exp_cnt);

    // Branch overrides a data stall; stalled add never enters the scoreboard
    step("bs_lw", enc_lw(5'd4, 5'd3), 1'b1, 1'b0, 1'b0, 3'b000);
    step("bs_stall", enc_add(5'd5, 5'd4, 5'd2), 1'b1, 1'b0, 1'b0, 3'b110);
    step("bs_flush", enc_add(5'd5, 5'd4, 5'd2), 1'b1, 1'b1, 1'b0, 3'b011);
    check_eq("bs_state_run", {30'b0, state_o}, {30'b0, S_RUN});
    step("bs_discard", enc_add(5'd7, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0, 3'b000);
    check_eq("bs_state_flush", {30'b0, state_o}, {30'b0, S_FLUSH});
    step("bs_after", NOP, 1'b0, 1'b0, 1'b0, 3'b000);
    check_eq("bs_state_back", {30'b0, state_o}, {30'b0, S_RUN});
    idle(3);

    // Memory wait freezes the scoreboard with lw in ID/EX
    step("mw_lw", enc_lw(5'd4, 5'd3), 1'b1, 1'b0, 1'b0, 3'b000);
    step("mw_busy", enc_add(5'd5, 5'd4, 5'd2), 1'b1, 1'b0, 1'b1, 3'b100);
    step("mw_busy", enc_add(5'd5, 5'd4, 5'd2), 1'b1, 1'b0, 1'b1, 3'b100);
    check_eq("mw_state_hold", {30'b0, state_o}, {30'b0, S_HOLD});
    step("mw_busy", enc_add(5'd5, 5'd4, 5'd2), 1'b1, 1'b0, 1'b1, 3'b100);
    for (int i = 0; i < LD_STALLS; i++)
      step("mw_ldu", enc_add(5'd5, 5'd4, 5'd2), 1'b1, 1'b0, 1'b0, 3'b110);
    step("mw_go", enc_add(5'd5, 5'd4, 5'd2), 1'b1, 1'b0, 1'b0, 3'b000);
    idle(3);
    check_eq("cnt_mw", {16'b0, stall_cnt}, exp_cnt);

    // mem_busy beats branch_taken; flush fires once the freeze ends
    step("mb_busy", enc_add(5'd9, 5'd3, 5'd2), 1'b1, 1'b1, 1'b1, 3'b100);
    step("mb_busy", enc_add(5'd9, 5'd3, 5'd2), 1'b1, 1'b1, 1'b1, 3'b100);
    check_eq("mb_state_hold", {30'b0, state_o}, {30'b0, S_HOLD});
    step("mb_flush", NOP, 1'b0, 1'b1, 1'b0, 3'b011);
    step("mb_after", NOP, 1'b0, 1'b0, 1'b0, 3'b000);
    check_eq("mb_state_run", {30'b0, state_o}, {30'b0, S_RUN});
    idle(2);
    check_eq("cnt_mb", {16'b0, stall_cnt}, exp_cnt);

    // Reset in the middle of a stall
    step("rm_lw", enc_lw(5'd4, 5'd3), 1'b1, 1'b0, 1'b0, 3'b000);
    step("rm_stall", enc_add(5'd5, 5'd4, 5'd2), 1'b1, 1'b0, 1'b0, 3'b110);
    nrst = 1'b0;
    #1;
    check_eq("rm_out", {29'b0, hz.stall, hz.chng2nop, hz.flush_if}, 32'd0);
    check_eq("rm_cnt", {16'b0, stall_cnt}, 32'd0);
    exp_cnt = 0;
    @(posedge clk);
    #2;
    nrst = 1'b1;
    step("rm_empty", enc_add(5'd5, 5'd4, 5'd2), 1'b1, 1'b0, 1'b0, 3'b000);
    idle(2);
    check_eq("cnt_post_rst", {16'b0, stall_cnt}, exp_cnt);

    // Saturation on the 4-bit counter instance
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hz2.mem_busy = 1'b1;
      if (i == 10) begin
        #1;
        check_eq("sat_mid", {28'b0, stall_cnt2}, 32'd10);
      end
    end
    @(negedge clk);
    hz2.mem_busy = 1'b0;
    #1;
    check_eq("sat_end", {28'b0, stall_cnt2}, 32'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
